// File: rtl/floo_pkg.sv
// Shared types for the narrow/wide offload arbiter.
package floo_pkg;

    // Source of an offload request; also the 1-bit tag stored per outstanding request.
    typedef enum logic {
        OffloadNarrow = 1'b0,
        OffloadWide   = 1'b1
    } offload_src_e;

    // Round-robin helper: the source that is not `src`.
    function automatic offload_src_e other_src(input offload_src_e src);
        return (src == OffloadNarrow) ? OffloadWide : OffloadNarrow;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with the common_cells fifo_v3 port shape
// (without the unused test-mode input). Read data is taken from the head entry.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;
    localparam int unsigned CntWidth  = ADDR_DEPTH + 1;

    logic [ADDR_DEPTH-1:0] rd_ptr_q;
    logic [ADDR_DEPTH-1:0] wr_ptr_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [FifoDepth];

    logic cnt_zero;
    logic bypass;
    logic do_push;
    logic do_pop;

    assign cnt_zero = (cnt_q == '0);
    assign full_o   = (cnt_q == CntWidth'(FifoDepth));
    assign empty_o  = cnt_zero && !(FALL_THROUGH && push_i);
    assign usage_o  = cnt_q[ADDR_DEPTH-1:0];
    // In fall-through mode a push into an empty FIFO can leave in the same cycle.
    assign bypass   = FALL_THROUGH && cnt_zero && push_i && pop_i;
    assign do_push  = push_i && !full_o && !bypass;
    assign do_pop   = pop_i && !empty_o && !bypass;
    assign data_o   = (FALL_THROUGH && cnt_zero) ? data_i : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : wr_ptr_q + ADDR_DEPTH'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : rd_ptr_q + ADDR_DEPTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/floo_offload_arbiter.sv
// Shares one offload unit between the narrow and wide router offload ports.
// Round-robin arbitration with grant lock; a tag FIFO steers in-order results back.
module floo_offload_arbiter
    import floo_pkg::*;
#(
    parameter int unsigned OpWidth         = 4,
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned WideDataWidth   = 512,
    parameter int unsigned MaxOutstanding  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [OpWidth-1:0]         narrow_req_op_i,
    input  logic [NarrowDataWidth-1:0] narrow_req_operand1_i,
    input  logic [NarrowDataWidth-1:0] narrow_req_operand2_i,
    input  logic                       narrow_req_valid_i,
    output logic                       narrow_req_ready_o,
    output logic [NarrowDataWidth-1:0] narrow_resp_result_o,
    output logic                       narrow_resp_valid_o,
    input  logic                       narrow_resp_ready_i,
    input  logic [OpWidth-1:0]         wide_req_op_i,
    input  logic [WideDataWidth-1:0]   wide_req_operand1_i,
    input  logic [WideDataWidth-1:0]   wide_req_operand2_i,
    input  logic                       wide_req_valid_i,
    output logic                       wide_req_ready_o,
    output logic [WideDataWidth-1:0]   wide_resp_result_o,
    output logic                       wide_resp_valid_o,
    input  logic                       wide_resp_ready_i,
    output logic [OpWidth-1:0]         unit_req_op_o,
    output logic [WideDataWidth-1:0]   unit_req_operand1_o,
    output logic [WideDataWidth-1:0]   unit_req_operand2_o,
    output logic                       unit_req_valid_o,
    input  logic                       unit_req_ready_i,
    input  logic [WideDataWidth-1:0]   unit_resp_result_i,
    input  logic                       unit_resp_valid_i,
    output logic                       unit_resp_ready_o
);

    localparam int unsigned TagAddrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    offload_src_e prio_q, prio_d;
    logic         lock_q, lock_d;
    offload_src_e lock_src_q, lock_src_d;

    offload_src_e grant_src;
    logic         grant_valid;
    logic         req_hs;
    logic         resp_pop;

    logic                    tag_full;
    logic                    tag_empty;
    logic [TagAddrWidth-1:0] tag_usage;
    logic [0:0]              tag_head_raw;
    offload_src_e            tag_head;

    assign tag_head = offload_src_e'(tag_head_raw);

    // Grant selection: a held grant wins, then a lone requester, then the priority holder.
    always_comb begin
        grant_src = prio_q;
        if (lock_q) begin
            grant_src = lock_src_q;
        end else if (narrow_req_valid_i && !wide_req_valid_i) begin
            grant_src = OffloadNarrow;
        end else if (wide_req_valid_i && !narrow_req_valid_i) begin
            grant_src = OffloadWide;
        end
    end

    // Forward the granted request; a full tag FIFO blocks forwarding regardless of pops
    // so no response-side signal reaches the request path combinationally.
    always_comb begin
        grant_valid         = (grant_src == OffloadWide) ? wide_req_valid_i : narrow_req_valid_i;
        unit_req_valid_o    = grant_valid && !tag_full;
        unit_req_op_o       = '0;
        unit_req_operand1_o = '0;
        unit_req_operand2_o = '0;
        if (grant_valid) begin
            if (grant_src == OffloadWide) begin
                unit_req_op_o       = wide_req_op_i;
                unit_req_operand1_o = wide_req_operand1_i;
                unit_req_operand2_o = wide_req_operand2_i;
            end else begin
                unit_req_op_o       = narrow_req_op_i;
                unit_req_operand1_o = WideDataWidth'(narrow_req_operand1_i);
                unit_req_operand2_o = WideDataWidth'(narrow_req_operand2_i);
            end
        end
        narrow_req_ready_o = grant_valid && (grant_src == OffloadNarrow) && unit_req_ready_i && !tag_full;
        wide_req_ready_o   = grant_valid && (grant_src == OffloadWide) && unit_req_ready_i && !tag_full;
        req_hs             = unit_req_valid_o && unit_req_ready_i;
    end

    // Lock and round-robin update: a stalled grant is held, a handshake hands priority over.
    always_comb begin
        prio_d     = prio_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (req_hs) begin
            lock_d = 1'b0;
            prio_d = other_src(grant_src);
        end else if (unit_req_valid_o) begin
            lock_d     = 1'b1;
            lock_src_d = grant_src;
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= OffloadNarrow;
            lock_q     <= 1'b0;
            lock_src_q <= OffloadNarrow;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

    // Steer the unit response to the port whose tag is at the FIFO head.
    always_comb begin
        narrow_resp_valid_o  = 1'b0;
        wide_resp_valid_o    = 1'b0;
        narrow_resp_result_o = '0;
        wide_resp_result_o   = '0;
        unit_resp_ready_o    = 1'b0;
        if (!tag_empty) begin
            if (tag_head == OffloadWide) begin
                wide_resp_valid_o  = unit_resp_valid_i;
                wide_resp_result_o = unit_resp_result_i;
                unit_resp_ready_o  = wide_resp_ready_i;
            end else begin
                narrow_resp_valid_o  = unit_resp_valid_i;
                narrow_resp_result_o = unit_resp_result_i[NarrowDataWidth-1:0];
                unit_resp_ready_o    = narrow_resp_ready_i;
            end
        end
        resp_pop = unit_resp_valid_i && unit_resp_ready_o;
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (1),
        .DEPTH        (MaxOutstanding)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .usage_o (tag_usage),
        .data_i  (grant_src),
        .push_i  (req_hs),
        .data_o  (tag_head_raw),
        .pop_i   (resp_pop)
    );

    // A unit result with nothing outstanding cannot be steered anywhere.
    resp_while_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(unit_resp_valid_i && tag_empty));

    tag_usage_consistent: assert property (@(posedge clk_i) disable iff (!rst_ni)
        tag_empty |-> (tag_usage == '0));

endmodule

// File: tb/tb_floo_offload_arbiter.sv
// Directed + randomized bench for floo_offload_arbiter against a queue-based reference model.
module tb_floo_offload_arbiter;

    localparam int OW = 4;
    localparam int NW = 64;
    localparam int WW = 512;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [OW-1:0] nop = '0, wop = '0;
    logic [NW-1:0] nop1 = '0, nop2 = '0;
    logic [WW-1:0] wop1 = '0, wop2 = '0, ures = '0;
    logic nv = 1'b0, wv = 1'b0, uready = 1'b0, urv = 1'b0, nrr = 1'b0, wrr = 1'b0;

    logic          narrow_req_ready, narrow_resp_valid, wide_req_ready, wide_resp_valid;
    logic          unit_req_valid, unit_resp_ready;
    logic [NW-1:0] narrow_resp_result;
    logic [WW-1:0] wide_resp_result, unit_req_operand1, unit_req_operand2;
    logic [OW-1:0] unit_req_op;

    floo_offload_arbiter #(
        .OpWidth(OW), .NarrowDataWidth(NW), .WideDataWidth(WW), .MaxOutstanding(MO)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .narrow_req_op_i       (nop),
        .narrow_req_operand1_i (nop1),
        .narrow_req_operand2_i (nop2),
        .narrow_req_valid_i    (nv),
        .narrow_req_ready_o    (narrow_req_ready),
        .narrow_resp_result_o  (narrow_resp_result),
        .narrow_resp_valid_o   (narrow_resp_valid),
        .narrow_resp_ready_i   (nrr),
        .wide_req_op_i         (wop),
        .wide_req_operand1_i   (wop1),
        .wide_req_operand2_i   (wop2),
        .wide_req_valid_i      (wv),
        .wide_req_ready_o      (wide_req_ready),
        .wide_resp_result_o    (wide_resp_result),
        .wide_resp_valid_o     (wide_resp_valid),
        .wide_resp_ready_i     (wrr),
        .unit_req_op_o         (unit_req_op),
        .unit_req_operand1_o   (unit_req_operand1),
        .unit_req_operand2_o   (unit_req_operand2),
        .unit_req_valid_o      (unit_req_valid),
        .unit_req_ready_i      (uready),
        .unit_resp_result_i    (ures),
        .unit_resp_valid_i     (urv),
        .unit_resp_ready_o     (unit_resp_ready)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: priority owner, held grant, and the queue of outstanding sources (0=narrow, 1=wide).
    bit m_prio = 1'b0;
    bit m_lock = 1'b0;
    bit m_lock_src = 1'b0;
    bit m_tags[$];
    bit last_nhs = 1'b0;
    bit last_whs = 1'b0;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] rand_wide();
        logic [WW-1:0] v;
        for (int i = 0; i < WW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic new_narrow();
        nop  = OW'($urandom_range(15));
        nop1 = {$urandom, $urandom};
        nop2 = {$urandom, $urandom};
    endtask

    task automatic new_wide();
        wop  = OW'($urandom_range(15));
        wop1 = rand_wide();
        wop2 = rand_wide();
    endtask

    task automatic model_reset();
        m_tags.delete();
        m_prio = 1'b0;
        m_lock = 1'b0;
        m_lock_src = 1'b0;
        last_nhs = 1'b0;
        last_whs = 1'b0;
    endtask

    // One clock cycle: predict from the model, compare at the falling edge, advance the model.
    task automatic step();
        bit g, gv, full, empty, head, e_uv, e_nr, e_wr, e_urr, e_nrv, e_wrv, hs, pop;
        logic [WW-1:0] e_op1, e_op2;
        logic [OW-1:0] e_op;
        if (m_lock) g = m_lock_src;
        else if (nv && !wv) g = 1'b0;
        else if (wv && !nv) g = 1'b1;
        else g = m_prio;
        gv    = g ? wv : nv;
        full  = (m_tags.size() >= MO);
        e_uv  = gv && !full;
        e_op  = g ? wop : nop;
        e_op1 = g ? wop1 : WW'(nop1);
        e_op2 = g ? wop2 : WW'(nop2);
        e_nr  = e_uv && !g && uready;
        e_wr  = e_uv && g && uready;
        empty = (m_tags.size() == 0);
        head  = empty ? 1'b0 : m_tags[0];
        e_nrv = !empty && !head && urv;
        e_wrv = !empty && head && urv;
        e_urr = !empty && (head ? wrr : nrr);
        @(negedge clk);
        check("unit_req_valid", unit_req_valid, e_uv);
        check("narrow_req_ready", narrow_req_ready, e_nr);
        check("wide_req_ready", wide_req_ready, e_wr);
        check("narrow_resp_valid", narrow_resp_valid, e_nrv);
        check("wide_resp_valid", wide_resp_valid, e_wrv);
        check("unit_resp_ready", unit_resp_ready, e_urr);
        if (e_uv) begin
            check("unit_req_op", unit_req_op, e_op);
            check("unit_req_operand1", unit_req_operand1, e_op1);
            check("unit_req_operand2", unit_req_operand2, e_op2);
        end
        if (e_nrv) check("narrow_resp_result", narrow_resp_result, ures[NW-1:0]);
        if (e_wrv) check("wide_resp_result", wide_resp_result, ures);
        hs  = e_uv && uready;
        pop = urv && e_urr;
        @(posedge clk);
        if (rst_n) begin
            if (pop) begin
                $display("t=%0t resp -> %s result=%0h", $time, head ? "wide" : "narrow", ures[31:0]);
                void'(m_tags.pop_front());
            end
            if (hs) begin
                $display("t=%0t req  <- %s op=%0h", $time, g ? "wide" : "narrow", e_op);
                m_tags.push_back(g);
                m_lock = 1'b0;
                m_prio = !g;
            end else if (e_uv) begin
                m_lock = 1'b1;
                m_lock_src = g;
            end
        end
        last_nhs = rst_n && hs && !g;
        last_whs = rst_n && hs && g;
        #1;
    endtask

    task automatic refresh_reqs();
        if (last_nhs) new_narrow();
        if (last_whs) new_wide();
    endtask

    task automatic drain();
        nv = 1'b0;
        wv = 1'b0;
        nrr = 1'b1;
        wrr = 1'b1;
        for (int i = 0; i < MO + 2; i++) begin
            urv = (m_tags.size() > 0);
            ures = rand_wide();
            step();
        end
        urv = 1'b0;
    endtask

    initial begin
        // Reset state with idle inputs
        step();
        #2;
        check("rst_unit_req_valid", unit_req_valid, 1'b0);
        check("rst_unit_resp_ready", unit_resp_ready, 1'b0);
        step();
        rst_n = 1'b1;

        // Narrow only: operands are zero-extended, result comes back on the narrow port
        nv = 1'b1; nop = 4'd3; nop1 = 64'h5; nop2 = 64'h7; uready = 1'b1;
        #2;
        check("t1_op", unit_req_op, 4'd3);
        check("t1_operand1", unit_req_operand1, 512'h5);
        check("t1_operand2", unit_req_operand2, 512'h7);
        step();
        nv = 1'b0;
        step();
        urv = 1'b1; nrr = 1'b1; ures = rand_wide(); ures[NW-1:0] = 64'hC;
        #2;
        check("t1_result", narrow_resp_result, 64'hC);
        check("t1_wide_silent", wide_resp_valid, 1'b0);
        step();
        urv = 1'b0;

        // Wide only round trip, hands priority back to narrow
        wv = 1'b1; new_wide();
        step();
        wv = 1'b0;
        urv = 1'b1; wrr = 1'b1; ures = rand_wide();
        step();
        urv = 1'b0;

        // Both valid, unit always ready: grants alternate N,W,N,W
        nv = 1'b1; wv = 1'b1; new_narrow(); new_wide();
        for (int i = 0; i < 4; i++) begin
            #2;
            check("alt_narrow_ready", narrow_req_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            step();
            refresh_reqs();
        end
        nv = 1'b0; wv = 1'b0; urv = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ures = WW'(i);
            #2;
            check("alt_resp_narrow", narrow_resp_valid, (i % 2 == 1) ? 1'b1 : 1'b0);
            step();
        end
        urv = 1'b0;

        // Lock: narrow stalled while wide has priority keeps its grant
        nv = 1'b1; new_narrow(); uready = 1'b1;
        step();
        new_narrow(); uready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        wv = 1'b1; new_wide();
        #2;
        check("lock_operand1", unit_req_operand1, WW'(nop1));
        check("lock_wide_ready", wide_req_ready, 1'b0);
        step();
        uready = 1'b1;
        #2;
        check("lock_narrow_ready", narrow_req_ready, 1'b1);
        step();
        nv = 1'b0;
        #2;
        check("lock_wide_next", wide_req_ready, 1'b1);
        step();
        wv = 1'b0;
        drain();

        // Full: four accepted without responses blocks forwarding until after a pop
        nv = 1'b1; wv = 1'b1; new_narrow(); new_wide(); uready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            refresh_reqs();
        end
        #2;
        check("full_unit_valid", unit_req_valid, 1'b0);
        check("full_narrow_ready", narrow_req_ready, 1'b0);
        check("full_wide_ready", wide_req_ready, 1'b0);
        step();
        urv = 1'b1; nrr = 1'b1; wrr = 1'b1; ures = rand_wide();
        #2;
        check("full_pop_cycle_valid", unit_req_valid, 1'b0);
        step();
        urv = 1'b0;
        #2;
        check("full_after_pop_valid", unit_req_valid, 1'b1);
        step();
        drain();

        // Push and pop in the same cycle at two outstanding
        nv = 1'b1; wv = 1'b1; new_narrow(); new_wide(); uready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            refresh_reqs();
        end
        urv = 1'b1; ures = rand_wide();
        step();
        refresh_reqs();
        urv = 1'b0;
        #2;
        check("pp_third_valid", unit_req_valid, 1'b1);
        step();
        refresh_reqs();
        step();
        refresh_reqs();
        #2;
        check("pp_full_after_two", unit_req_valid, 1'b0);
        drain();

        // Reset with three outstanding
        nv = 1'b1; wv = 1'b1; new_narrow(); new_wide(); uready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            refresh_reqs();
        end
        nv = 1'b0; wv = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check("mid_rst_resp_ready", unit_resp_ready, 1'b0);
        check("mid_rst_narrow_valid", narrow_resp_valid, 1'b0);
        check("mid_rst_wide_valid", wide_resp_valid, 1'b0);
        step();
        rst_n = 1'b1;
        nv = 1'b1; wv = 1'b1; new_narrow(); new_wide();
        #2;
        check("post_rst_narrow_first", narrow_req_ready, 1'b1);
        check("post_rst_wide_wait", wide_req_ready, 1'b0);
        step();

        // Randomized traffic, requesters hold valid/data until accepted
        for (int c = 0; c < 400; c++) begin
            if (!nv || last_nhs) begin
                nv = ($urandom_range(99) < 60);
                new_narrow();
            end
            if (!wv || last_whs) begin
                wv = ($urandom_range(99) < 60);
                new_wide();
            end
            uready = ($urandom_range(3) != 0);
            nrr = ($urandom_range(3) != 0);
            wrr = ($urandom_range(3) != 0);
            urv = (m_tags.size() > 0) && ($urandom_range(1) == 1);
            ures = rand_wide();
            step();
        end
        // Let pending requests complete before draining
        for (int c = 0; c < 12; c++) begin
            if (last_nhs) nv = 1'b0;
            if (last_whs) wv = 1'b0;
            uready = 1'b1; nrr = 1'b1; wrr = 1'b1;
            urv = (m_tags.size() > 0);
            ures = rand_wide();
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
